// File: rtl/uart_rx_fifo_pkg.sv
// Register map, CTRL bit positions and register layouts for the UART receive FIFO window.
// Shared by the RTL; firmware headers mirror these offsets and bit positions.
package uart_rx_fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        overflow;
        logic        full;
        logic        empty;
    } status_t;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  threshold;
        logic [4:0]  rsvd_lo;
        logic        irq_en;
        logic [1:0]  rsvd_cmd;
    } ctrl_t;

    // A zero threshold behaves as 1 so an empty FIFO never requests service.
    function automatic logic [7:0] thr_eff(input logic [7:0] thr);
        return (thr == 8'd0) ? 8'd1 : thr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// buart ingress handshake plus CPU register-window signals for uart_rx_fifo.
// master = buart/CPU side, slave = the FIFO block.
interface uart_rx_fifo_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        select;
    logic        rd;
    logic [3:0]  wr;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        interrupt;

    modport master (
        output rx_data, rx_valid, select, rd, wr, addr, data_in,
        input  rx_ack, data_out, interrupt
    );

    modport slave (
        input  rx_data, rx_valid, select, rd, wr, addr, data_in,
        output rx_ack, data_out, interrupt
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// 2^AW x DW register-file storage: synchronous write, asynchronous head read.
// No flow control here; the owner guarantees writes only land in free slots.
module sync_fifo_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Drains buart bytes into a FIFO read by the CPU; push 1 edge after rx_valid, read data 1 cycle after strobe.
// No backpressure to buart: a byte arriving while full is acked and dropped, setting overflow.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam logic [0:0]            S_IDLE   = 1'b0;
    localparam logic [0:0]            S_DRAIN  = 1'b1;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [0:0]            r_state;
    logic                  r_rx_ack;
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow, r_irq_en;
    logic [7:0]            r_threshold;
    logic [31:0]           r_data_out;

    logic        w_empty, w_full, w_take, w_rd, w_pop, w_push;
    logic        w_ctrl_wr, w_flush, w_clr_ovf, w_ovf_set;
    logic [7:0]  w_head;
    logic [8:0]  w_cnt9, w_thr9;
    logic [31:0] w_rd_mux;
    status_t     w_status;
    ctrl_t       w_ctrl;
    logic        w_unused;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_take    = (r_state == S_IDLE) && bus.rx_valid;
    assign w_rd      = bus.select && bus.rd;
    assign w_pop     = w_rd && (bus.addr == REG_DATA) && !w_empty;
    assign w_ctrl_wr = bus.select && (bus.addr == REG_CTRL) && bus.wr[0];
    assign w_flush   = w_ctrl_wr && bus.data_in[CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_ctrl_wr && bus.data_in[CTRL_CLR_OVF_BIT];
    // A concurrent pop frees the slot, so a full FIFO still accepts the byte.
    assign w_push    = w_take && !w_flush && (!w_full || w_pop);
    assign w_ovf_set = w_take && !w_flush && w_full && !w_pop;

    sync_fifo_mem #(.AW(DEPTH_LOG2), .DW(8)) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (bus.rx_data),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rx_ack <= 1'b0;
        end else begin
            r_rx_ack <= w_take;
            case (r_state)
                S_IDLE:  if (bus.rx_valid)  r_state <= S_DRAIN;
                default: if (!bus.rx_valid) r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_threshold <= 8'd1;
        end else begin
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_clr_ovf) r_overflow <= 1'b0;
            if (w_ctrl_wr) r_irq_en <= bus.data_in[CTRL_IRQ_EN_BIT];
            if (bus.select && (bus.addr == REG_CTRL) && bus.wr[1])
                r_threshold <= bus.data_in[15:8];
        end
    end

    always_comb begin
        w_status          = '0;
        w_status.count    = 8'(r_count);
        w_status.overflow = r_overflow;
        w_status.full     = w_full;
        w_status.empty    = w_empty;
        w_ctrl            = '0;
        w_ctrl.threshold  = r_threshold;
        w_ctrl.irq_en     = r_irq_en;
        w_rd_mux          = '0;
        case (bus.addr)
            REG_DATA:   if (!w_empty) w_rd_mux = {23'b0, 1'b1, w_head};
            REG_STATUS: w_rd_mux = w_status;
            REG_CTRL:   w_rd_mux = w_ctrl;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_data_out <= '0;
        else if (w_rd) r_data_out <= w_rd_mux;
    end

    assign w_cnt9 = 9'(r_count);
    assign w_thr9 = {1'b0, thr_eff(r_threshold)};

    assign bus.rx_ack    = r_rx_ack;
    assign bus.data_out  = r_data_out;
    assign bus.interrupt = r_irq_en && ((w_cnt9 >= w_thr9) || r_overflow);

    assign w_unused = ^{bus.data_in[31:16], bus.data_in[7:3], bus.wr[3:2]};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: register table plus scoreboarded ingress/readback sequences.
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) if (bus.rx_ack === 1'b1) ack_cnt++;

    typedef struct {
        logic [1:0]  waddr;
        logic [3:0]  wr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input bit ovf);
        logic [7:0] c;
        c = 8'(cnt);
        return {16'b0, c, 5'b0, ovf, (cnt == 16), (cnt == 0)};
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        bus.select = 1'b1; bus.wr = w; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.select = 1'b0; bus.wr = 4'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.select = 1'b1; bus.rd = 1'b1; bus.addr = a;
        @(negedge clk);
        bus.select = 1'b0; bus.rd = 1'b0;
        d = bus.data_out;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic data_check(input string name);
        logic [31:0] d, exp;
        exp = 32'h0;
        if (exp_q.size() != 0) exp = {23'b0, 1'b1, exp_q.pop_front()};
        bus_read(2'd0, d);
        check(name, d, exp);
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_ack === 1'b1) got = 1'b1;
        end
        bus.rx_valid = 1'b0;
        check(name, {31'b0, got}, 32'h1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accept);
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = b;
        wait_ack("send_ack");
        if (accept) exp_q.push_back(b);
        @(negedge clk);
    endtask

    // Byte arrives on the same edge as a DATA read strobe.
    task automatic push_and_pop(input string name, input logic [7:0] b);
        logic [31:0] exp;
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = b;
        bus.select = 1'b1; bus.rd = 1'b1; bus.addr = 2'd0;
        @(negedge clk);
        bus.select = 1'b0; bus.rd = 1'b0;
        exp = 32'h0;
        if (exp_q.size() != 0) exp = {23'b0, 1'b1, exp_q.pop_front()};
        exp_q.push_back(b);
        check(name, bus.data_out, exp);
        check({name, "_ack"}, {31'b0, bus.rx_ack}, 32'h1);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    vec_t vt[11];
    int   a0;

    initial begin
        reset = 1'b1;
        bus.rx_data = 8'h0; bus.rx_valid = 1'b0; bus.select = 1'b0; bus.rd = 1'b0;
        bus.wr = 4'h0; bus.addr = 2'd0; bus.data_in = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack",  {31'b0, bus.rx_ack},    32'h0);
        check("rst_irq",  {31'b0, bus.interrupt}, 32'h0);
        check("rst_dout", bus.data_out,           32'h0);
        reset = 1'b0;

        vt[0]  = '{2'd0, 4'h0, 32'h0,        2'd1, 32'h0000_0001};
        vt[1]  = '{2'd0, 4'h0, 32'h0,        2'd0, 32'h0000_0000};
        vt[2]  = '{2'd0, 4'h0, 32'h0,        2'd2, 32'h0000_0100};
        vt[3]  = '{2'd0, 4'h0, 32'h0,        2'd3, 32'h0000_0000};
        vt[4]  = '{2'd2, 4'h3, 32'h0000_0504, 2'd2, 32'h0000_0504};
        vt[5]  = '{2'd2, 4'h2, 32'h0000_0900, 2'd2, 32'h0000_0904};
        vt[6]  = '{2'd2, 4'h1, 32'h0000_0003, 2'd2, 32'h0000_0900};
        vt[7]  = '{2'd0, 4'hF, 32'hFFFF_FFFF, 2'd1, 32'h0000_0001};
        vt[8]  = '{2'd3, 4'hF, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
        vt[9]  = '{2'd2, 4'hC, 32'hFFFF_FFFF, 2'd2, 32'h0000_0900};
        vt[10] = '{2'd2, 4'h3, 32'h0000_0100, 2'd2, 32'h0000_0100};
        for (int i = 0; i < 11; i++) begin
            logic [31:0] d;
            if (vt[i].wr != 4'h0) bus_write(vt[i].waddr, vt[i].wr, vt[i].wdata);
            bus_read(vt[i].raddr, d);
            check($sformatf("vec%0d", i), d, vt[i].exp);
        end
        check("tbl_irq", {31'b0, bus.interrupt}, 32'h0);

        // Threshold 2 interrupt, then in-order readback.
        bus_write(2'd2, 4'h3, 32'h0000_0204);
        send_byte(8'h41, 1'b1);
        check("irq_cnt1", {31'b0, bus.interrupt}, 32'h0);
        send_byte(8'h42, 1'b1);
        check("irq_cnt2", {31'b0, bus.interrupt}, 32'h1);
        send_byte(8'h43, 1'b1);
        for (int i = 0; i < 4; i++) data_check($sformatf("abc_rd%0d", i));
        check("irq_drained", {31'b0, bus.interrupt}, 32'h0);

        // Overflow: 17 bytes into 16 slots.
        bus_write(2'd2, 4'h3, 32'h0000_1100);
        a0 = ack_cnt;
        for (int i = 0; i < 17; i++) send_byte(8'h60 + 8'(i), i < 16);
        check("ovf_acks", 32'(ack_cnt - a0), 32'd17);
        read_check("ovf_status", 2'd1, st(16, 1'b1));
        bus_write(2'd2, 4'h1, 32'h0000_0004);
        check("ovf_irq", {31'b0, bus.interrupt}, 32'h1);
        bus_write(2'd2, 4'h1, 32'h0000_0002);
        read_check("ovf_clr", 2'd1, st(16, 1'b0));
        bus_write(2'd2, 4'h1, 32'h0000_0004);
        check("thr17_irq", {31'b0, bus.interrupt}, 32'h0);
        bus_write(2'd2, 4'h2, 32'h0000_1000);
        check("thr16_irq", {31'b0, bus.interrupt}, 32'h1);
        bus_write(2'd2, 4'h3, 32'h0000_0100);
        for (int i = 0; i < 17; i++) data_check($sformatf("ovf_rd%0d", i));

        // rx_valid held high: one ack, one push.
        a0 = ack_cnt;
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
        repeat (5) @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h77);
        check("hold_acks", 32'(ack_cnt - a0), 32'd1);
        read_check("hold_status", 2'd1, st(1, 1'b0));
        bus_write(2'd2, 4'h3, 32'h0000_0004);
        check("thr0_irq", {31'b0, bus.interrupt}, 32'h1);
        bus_write(2'd2, 4'h3, 32'h0000_0100);

        // Concurrent push and pop at count 3, then at full.
        send_byte(8'h81, 1'b1);
        send_byte(8'h82, 1'b1);
        push_and_pop("pp3", 8'h83);
        read_check("pp3_status", 2'd1, st(3, 1'b0));
        for (int i = 0; i < 4; i++) data_check($sformatf("pp3_rd%0d", i));
        for (int i = 0; i < 16; i++) send_byte(8'h90 + 8'(i), 1'b1);
        push_and_pop("ppfull", 8'hA0);
        read_check("ppfull_status", 2'd1, st(16, 1'b0));
        for (int i = 0; i < 17; i++) data_check($sformatf("ppfull_rd%0d", i));

        // Flush coincident with a push at count 5.
        for (int i = 0; i < 5; i++) send_byte(8'hB0 + 8'(i), 1'b1);
        read_check("fl_pre", 2'd1, st(5, 1'b0));
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 8'hEE;
        bus.select = 1'b1; bus.wr = 4'h1; bus.addr = 2'd2; bus.data_in = 32'h1;
        @(negedge clk);
        bus.select = 1'b0; bus.wr = 4'h0;
        check("fl_ack", {31'b0, bus.rx_ack}, 32'h1);
        bus.rx_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        read_check("fl_status", 2'd1, st(0, 1'b0));
        data_check("fl_rd");
        push_and_pop("pp_empty", 8'hC3);
        read_check("ppe_status", 2'd1, st(1, 1'b0));
        data_check("ppe_rd");

        // Reset mid-transfer; pending byte is re-acked afterwards.
        bus_write(2'd2, 4'h3, 32'h0000_0304);
        send_byte(8'hD1, 1'b1);
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
        #2 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {31'b0, bus.rx_ack},    32'h0);
        check("mid_rst_irq", {31'b0, bus.interrupt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        wait_ack("rst_reack");
        exp_q.push_back(8'h55);
        @(negedge clk);
        read_check("rst_status", 2'd1, st(1, 1'b0));
        read_check("rst_ctrl",   2'd2, 32'h0000_0100);
        data_check("rst_rd0");
        data_check("rst_rd1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
